// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the pipeline stall/flush sequencer.
// The controller state encoding, the load opcode (shared with the decoder)
// and the hard-wired zero register all live here.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hazard_state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Decoder-side helper: true when the opcode field denotes a load.
    function automatic logic is_load_op(input logic [6:0] i_op);
        return (i_op == OP_LOAD);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: bundle of the ID/EX/MEM status signals seen by the
// hazard controller and the freeze/bubble/flush controls it returns.
// slave  = the hazard controller, master = the pipeline datapath side.
interface pipeline_hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       ex_valid_i;
    logic       ex_is_load_i;
    logic [4:0] ex_rsd_i;
    logic       branch_taken_i;
    logic       dmem_req_i;
    logic       dmem_ack_i;

    logic       pc_stall_o;
    logic       if_id_stall_o;
    logic       if_id_flush_o;
    logic       id_ex_stall_o;
    logic       id_ex_bubble_o;
    logic       ex_mem_stall_o;
    logic       err_o;
    logic [1:0] state_o;

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i,
        input  ex_valid_i, ex_is_load_i, ex_rsd_i,
        input  branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o,
        output id_ex_stall_o, id_ex_bubble_o, ex_mem_stall_o,
        output err_o, state_o
    );

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i,
        output ex_valid_i, ex_is_load_i, ex_rsd_i,
        output branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o,
        input  id_ex_stall_o, id_ex_bubble_o, ex_mem_stall_o,
        input  err_o, state_o
    );

endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: purely combinational load-use compare between the load in EX
// and the source registers of the instruction in ID. x0 never matches.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_ex_valid,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rsd,
    output logic       o_load_use
);

    logic w_srcMatch;

    assign w_srcMatch = (i_ex_rsd == i_id_rs1) || (i_ex_rsd == i_id_rs2);

    assign o_load_use = i_ex_valid && i_ex_is_load && (i_ex_rsd != REG_ZERO) &&
                        i_id_valid && w_srcMatch;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Memory waits freeze the whole pipeline, load-use inserts one bubble, taken
// branches flush IF/ID; a memory access that never acks parks the controller
// in a sticky error state until reset.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// cycle counters on stall_cnt_o / flush_cnt_o.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
)
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

    localparam logic [1:0] S_RUN      = ST_RUN;
    localparam logic [1:0] S_MEM_WAIT = ST_MEM_WAIT;
    localparam logic [1:0] S_ERR      = ST_ERR;

    localparam int             CW         = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0]  WAIT_ONE   = CW'(1);
    localparam logic [CW-1:0]  WAIT_LAST  = CW'(MEM_TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_waitCnt;
    logic          r_err;

    logic w_loadUse;
    logic w_inRun;
    logic w_inWait;
    logic w_inErr;
    logic w_freeze;
    logic w_pcStall;
    logic w_flush;

    hazard_detect u_detect (
        .i_id_valid   (bus.id_valid_i),
        .i_id_rs1     (bus.id_rs1_i),
        .i_id_rs2     (bus.id_rs2_i),
        .i_ex_valid   (bus.ex_valid_i),
        .i_ex_is_load (bus.ex_is_load_i),
        .i_ex_rsd     (bus.ex_rsd_i),
        .o_load_use   (w_loadUse)
    );

    assign w_inRun  = (r_state == S_RUN);
    assign w_inWait = (r_state == S_MEM_WAIT);
    assign w_inErr  = (r_state == S_ERR);

    assign w_freeze = (w_inRun && bus.dmem_req_i && !bus.dmem_ack_i) ||
                      (w_inWait && !bus.dmem_ack_i) ||
                      w_inErr;

    // Output priority: freeze beats load-use beats branch flush; reset masks all.
    always_comb begin
        bus.pc_stall_o     = 1'b0;
        bus.if_id_stall_o  = 1'b0;
        bus.if_id_flush_o  = 1'b0;
        bus.id_ex_stall_o  = 1'b0;
        bus.id_ex_bubble_o = 1'b0;
        bus.ex_mem_stall_o = 1'b0;
        if (!rst_i) begin
            if (w_freeze) begin
                bus.pc_stall_o     = 1'b1;
                bus.if_id_stall_o  = 1'b1;
                bus.id_ex_stall_o  = 1'b1;
                bus.ex_mem_stall_o = 1'b1;
            end else if (w_loadUse) begin
                bus.pc_stall_o     = 1'b1;
                bus.if_id_stall_o  = 1'b1;
                bus.id_ex_bubble_o = 1'b1;
            end else if (bus.branch_taken_i) begin
                bus.if_id_flush_o  = 1'b1;
            end
        end
    end

    assign bus.err_o   = r_err && !rst_i;
    assign bus.state_o = rst_i ? S_RUN : r_state;
    assign w_pcStall   = bus.pc_stall_o;
    assign w_flush     = bus.if_id_flush_o;

    // Memory-wait FSM: counts unacked wait cycles and traps into ERR on timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_RUN;
            r_waitCnt <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.dmem_req_i && !bus.dmem_ack_i) begin
                        r_state   <= S_MEM_WAIT;
                        r_waitCnt <= WAIT_ONE;
                    end
                end
                S_MEM_WAIT: begin
                    if (bus.dmem_ack_i) begin
                        r_state   <= S_RUN;
                        r_waitCnt <= '0;
                    end else if (r_waitCnt == WAIT_LAST) begin
                        r_state   <= S_ERR;
                        r_err     <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + WAIT_ONE;
                    end
                end
                S_ERR: begin
                    r_err <= 1'b1;
                end
                default: begin
                    r_state   <= S_RUN;
                    r_waitCnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    // Saturating counts of PC-stall cycles and IF/ID flush cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_pcStall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (w_flush && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = rst_i ? '0 : r_stallCnt;
    assign flush_cnt_o = rst_i ? '0 : r_flushCnt;
`else
    logic w_unusedPerf;
    assign w_unusedPerf = w_pcStall ^ w_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for the pipeline hazard controller.
// A behavioural model tracks the outstanding memory access, the number of
// unacked cycles and the sticky error, and predicts every output each cycle;
// directed vectors additionally pin hand-computed literal results.
// Built with HAZARD_PERF_CNT_EN the perf counters are checked as well.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall, err, state[1:0]}
    localparam logic [8:0] EXP_IDLE     = 9'b000000000;
    localparam logic [8:0] EXP_LU       = 9'b110010000;
    localparam logic [8:0] EXP_LU_WAIT  = 9'b110010001;
    localparam logic [8:0] EXP_FRZ_RUN  = 9'b110101000;
    localparam logic [8:0] EXP_FRZ_WAIT = 9'b110101001;
    localparam logic [8:0] EXP_ACK      = 9'b000000001;
    localparam logic [8:0] EXP_FLUSH    = 9'b001000000;
    localparam logic [8:0] EXP_ERR      = 9'b110101110;

    logic clk;
    logic rst;

    pipeline_hazard_ctrl_if hif();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;
`endif

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (hif)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt_o (stallCnt),
        .flush_cnt_o (flushCnt)
`endif
    );

    int vectorCount = 0;
    int missCount   = 0;

    bit mPending = 1'b0;
    bit mErr     = 1'b0;
    int mUnacked = 0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] actualVec();
        return {hif.pc_stall_o, hif.if_id_stall_o, hif.if_id_flush_o,
                hif.id_ex_stall_o, hif.id_ex_bubble_o, hif.ex_mem_stall_o,
                hif.err_o, hif.state_o};
    endfunction

    // Prediction from the rules: memory outstanding or errored freezes,
    // otherwise a load feeding ID bubbles, otherwise a taken branch flushes.
    function automatic logic [8:0] modelVec();
        logic       loadUse;
        logic       freeze;
        logic [1:0] st;
        if (rst) return EXP_IDLE;
        loadUse = hif.ex_valid_i && hif.ex_is_load_i && (hif.ex_rsd_i != 5'd0) &&
                  hif.id_valid_i &&
                  ((hif.ex_rsd_i == hif.id_rs1_i) || (hif.ex_rsd_i == hif.id_rs2_i));
        freeze  = mErr || (!hif.dmem_ack_i && (mPending || hif.dmem_req_i));
        st      = mErr ? 2'd2 : (mPending ? 2'd1 : 2'd0);
        if (freeze)                  return {6'b110101, mErr, st};
        else if (loadUse)            return {6'b110010, 1'b0, st};
        else if (hif.branch_taken_i) return {6'b001000, 1'b0, st};
        else                         return {6'b000000, 1'b0, st};
    endfunction

    // Model state update: an access stays outstanding until acked and
    // becomes an error once it has gone MEM_TIMEOUT cycles unacked.
    always @(posedge clk) begin
        if (rst) begin
            mPending <= 1'b0;
            mErr     <= 1'b0;
            mUnacked <= 0;
        end else if (!mErr) begin
            if (hif.dmem_ack_i) begin
                mPending <= 1'b0;
                mUnacked <= 0;
            end else if (mPending || hif.dmem_req_i) begin
                mPending <= 1'b1;
                mUnacked <= mUnacked + 1;
                if (mUnacked + 1 == MEM_TIMEOUT) mErr <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            vectorCount++;
            if (actualVec() !== modelVec()) begin
                missCount++;
                $display("[TB] FAIL model_cycle t=%0t: actual=%b required=%b",
                         $time, actualVec(), modelVec());
            end
        end
    end

    // Hard bound on the run in case the sequence ever stops advancing.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic idv,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic exv, input logic ld, input logic [4:0] rsd,
                                 input logic br, input logic req, input logic ack);
        @(posedge clk);
        #1;
        rst                = r;
        hif.id_valid_i     = idv;
        hif.id_rs1_i       = rs1;
        hif.id_rs2_i       = rs2;
        hif.ex_valid_i     = exv;
        hif.ex_is_load_i   = ld;
        hif.ex_rsd_i       = rsd;
        hif.branch_taken_i = br;
        hif.dmem_req_i     = req;
        hif.dmem_ack_i     = ack;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] expected);
        @(negedge clk);
        vectorCount++;
        if (actualVec() !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: actual=%b required=%b", name, actualVec(), expected);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic checkPerf(input string name, input int expStall, input int expFlush);
        vectorCount++;
        if (stallCnt !== 32'(expStall) || flushCnt !== 32'(expFlush)) begin
            missCount++;
            $display("[TB] FAIL %s: actual stall=%0d flush=%0d required stall=%0d flush=%0d",
                     name, stallCnt, flushCnt, expStall, expFlush);
        end
    endtask
`endif

    // Directed sequence.
    initial begin
        rst                = 1'b1;
        hif.id_valid_i     = 1'b0;
        hif.id_rs1_i       = 5'd0;
        hif.id_rs2_i       = 5'd0;
        hif.ex_valid_i     = 1'b0;
        hif.ex_is_load_i   = 1'b0;
        hif.ex_rsd_i       = 5'd0;
        hif.branch_taken_i = 1'b1;
        hif.dmem_req_i     = 1'b1;
        hif.dmem_ack_i     = 1'b0;
        checkOutput("reset_gates_outputs", EXP_IDLE);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_idle", EXP_IDLE);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("run_idle", EXP_IDLE);

        applyStimulus(0, 1, 5, 0, 1, 1, 5, 0, 0, 0);
        checkOutput("lu_rs1", EXP_LU);
        applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lu_advanced", EXP_IDLE);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("mem_req_noack", EXP_FRZ_RUN);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("mem_wait", EXP_FRZ_WAIT);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("mem_ack_unfreeze", EXP_ACK);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("after_ack", EXP_IDLE);
`ifdef HAZARD_PERF_CNT_EN
        checkPerf("perf_after_lu_and_wait", 4, 0);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("branch_flush", EXP_FLUSH);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("after_flush", EXP_IDLE);
`ifdef HAZARD_PERF_CNT_EN
        checkPerf("perf_after_branch", 4, 1);
`endif

        applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("x0_no_hazard", EXP_IDLE);
        applyStimulus(0, 1, 3, 5, 1, 1, 5, 0, 0, 0);
        checkOutput("lu_rs2", EXP_LU);
        applyStimulus(0, 1, 3, 5, 1, 0, 5, 0, 0, 0);
        checkOutput("not_load", EXP_IDLE);
        applyStimulus(0, 0, 5, 5, 1, 1, 5, 0, 0, 0);
        checkOutput("id_invalid", EXP_IDLE);
        applyStimulus(0, 1, 5, 5, 0, 1, 5, 0, 0, 0);
        checkOutput("ex_invalid", EXP_IDLE);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("zero_wait_flush", EXP_FLUSH);

        applyStimulus(0, 1, 5, 0, 1, 1, 5, 1, 1, 0);
        checkOutput("freeze_over_all", EXP_FRZ_RUN);
        applyStimulus(0, 1, 5, 0, 1, 1, 5, 1, 1, 0);
        checkOutput("freeze_wait_over_all", EXP_FRZ_WAIT);
        applyStimulus(0, 1, 5, 0, 1, 1, 5, 1, 1, 1);
        checkOutput("ack_lu_first", EXP_LU_WAIT);
        applyStimulus(0, 1, 5, 0, 1, 1, 5, 1, 0, 0);
        checkOutput("lu_held", EXP_LU);
        applyStimulus(0, 1, 5, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("flush_after_lu", EXP_FLUSH);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_2", EXP_IDLE);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("wait_then_reset_a", EXP_FRZ_RUN);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("wait_then_reset_b", EXP_FRZ_WAIT);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("reset_mid_wait", EXP_IDLE);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("run_after_reset", EXP_IDLE);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("timeout_start", EXP_FRZ_RUN);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("timeout_wait", EXP_FRZ_WAIT);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("err_entry", EXP_ERR);
        applyStimulus(0, 1, 5, 0, 1, 1, 5, 1, 0, 0);
        checkOutput("err_sticky", EXP_ERR);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("err_ignores_ack", EXP_ERR);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("err_reset", EXP_IDLE);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("after_err_reset", EXP_IDLE);
        applyStimulus(0, 1, 7, 0, 1, 1, 7, 0, 0, 0);
        checkOutput("lu_after_err_reset", EXP_LU);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
